// File: rtl/bf_pkg.sv
// Shared definitions for the 16-lamp bound flasher.
//   bf_state_e : phase encoding (IDLE=0, S1..S6=1..6)
//   NUM_LAMPS  : number of lamp outputs
//   KB_LO/KB_HI: lit counts at which a kickback may be requested
//   MID        : lit count where the S4 -> S5 turnaround happens
//   therm()    : lit count -> thermometer-coded lamp vector
package bf_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S1   = 3'd1,
        S2   = 3'd2,
        S3   = 3'd3,
        S4   = 3'd4,
        S5   = 3'd5,
        S6   = 3'd6
    } bf_state_e;

    localparam int NUM_LAMPS = 16;
    localparam int KB_LO     = 6;
    localparam int KB_HI     = 11;
    localparam int MID       = 5;
    localparam int N_W       = 5;

    function automatic logic [NUM_LAMPS-1:0] therm(input logic [N_W-1:0] n);
        logic [NUM_LAMPS-1:0] t;
        t = '0;
        for (int i = 0; i < NUM_LAMPS; i++) begin
            t[i] = (n > N_W'(i));
        end
        return t;
    endfunction

endpackage

// File: rtl/bf_step_prescaler.sv
// Step-rate prescaler: asserts tick for one clk cycle every STEP_DIV cycles.
//   clk   in  system clock, rising edge
//   rst_n in  asynchronous active-low reset
//   tick  out step enable (constantly 1 when STEP_DIV == 1)
// Down-counter with terminal count at zero. It resets to zero, so the first
// cycle after reset release is already a tick.
module bf_step_prescaler #(
    parameter int STEP_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/bound_flasher_sequencer.sv
// Bound flasher sequencer: phase FSM plus lit-lamp count for 16 lamps.
//   clk     in  system clock, rising edge
//   rst_n   in  asynchronous active-low reset
//   flick   in  start / kickback request (clk-synchronous)
//   lamp    out thermometer code of the lit count N (registered)
//   state_o out current phase
//   busy    out 1 whenever the phase is not IDLE
//
// state | meaning
// IDLE  | all lamps off, waiting for flick
// S1    | lighting up to lamp5 (N 1..6)
// S2    | turning off down to 0
// S3    | lighting up to lamp10, kickback to S2 at N=6 or N=11
// S4    | turning off down to lamp5
// S5    | lighting up to lamp15, kickback to S4 at N=11
// S6    | turning off down to 0, then back to IDLE
module bound_flasher_sequencer
    import bf_pkg::*;
#(
    parameter int STEP_DIV = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flick,
    output logic [NUM_LAMPS-1:0] lamp,
    output logic [2:0]           state_o,
    output logic                 busy
);

    localparam logic [N_W-1:0] N_ZERO  = '0;
    localparam logic [N_W-1:0] N_ONE   = N_W'(1);
    localparam logic [N_W-1:0] N_MID   = N_W'(MID);
    localparam logic [N_W-1:0] N_KB_LO = N_W'(KB_LO);
    localparam logic [N_W-1:0] N_KB_HI = N_W'(KB_HI);
    localparam logic [N_W-1:0] N_FULL  = N_W'(NUM_LAMPS);

    logic            tick;
    bf_state_e       state_q;
    bf_state_e       state_nxt;
    logic [N_W-1:0]  n_q;
    logic [N_W-1:0]  n_nxt;

    bf_step_prescaler #(
        .STEP_DIV (STEP_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // A phase exit already takes the first step of the following phase, so
    // every non-IDLE tick moves N by exactly one.
    always_comb begin
        state_nxt = state_q;
        n_nxt     = n_q;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (flick) begin
                        state_nxt = S1;
                        n_nxt     = N_ONE;
                    end else begin
                        n_nxt = N_ZERO;
                    end
                end
                S1: begin
                    if (n_q == N_KB_LO) begin
                        state_nxt = S2;
                        n_nxt     = n_q - 1'b1;
                    end else begin
                        n_nxt = n_q + 1'b1;
                    end
                end
                S2: begin
                    if (n_q == N_ZERO) begin
                        state_nxt = S3;
                        n_nxt     = N_ONE;
                    end else begin
                        n_nxt = n_q - 1'b1;
                    end
                end
                S3: begin
                    if (flick && (n_q == N_KB_LO || n_q == N_KB_HI)) begin
                        state_nxt = S2;
                        n_nxt     = n_q - 1'b1;
                    end else if (n_q == N_KB_HI) begin
                        state_nxt = S4;
                        n_nxt     = n_q - 1'b1;
                    end else begin
                        n_nxt = n_q + 1'b1;
                    end
                end
                S4: begin
                    if (n_q == N_MID) begin
                        state_nxt = S5;
                        n_nxt     = n_q + 1'b1;
                    end else begin
                        n_nxt = n_q - 1'b1;
                    end
                end
                S5: begin
                    if (flick && n_q == N_KB_HI) begin
                        state_nxt = S4;
                        n_nxt     = n_q - 1'b1;
                    end else if (n_q == N_FULL) begin
                        state_nxt = S6;
                        n_nxt     = n_q - 1'b1;
                    end else begin
                        n_nxt = n_q + 1'b1;
                    end
                end
                S6: begin
                    if (n_q == N_ZERO) begin
                        state_nxt = IDLE;
                    end else begin
                        n_nxt = n_q - 1'b1;
                    end
                end
                default: begin
                    // unused code: recover to a clean IDLE
                    state_nxt = IDLE;
                    n_nxt     = N_ZERO;
                end
            endcase
        end
    end

    // lamp is decoded from n_nxt so it lands in the same edge as N itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            n_q     <= N_ZERO;
            lamp    <= '0;
        end else begin
            state_q <= state_nxt;
            n_q     <= n_nxt;
            lamp    <= therm(n_nxt);
        end
    end

    assign state_o = state_q;
    assign busy    = (state_q != IDLE);

endmodule
